// File: rtl/sum_accum_pkg.sv
// Shared types and widths for the block accumulator: FSM states, the
// sample-counter width and the width of one incoming adder result.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Sample counter width; wide enough for block sizes up to 15.
  localparam int CNT_W = 4;

  // One adder result is carry-out plus a 2-bit sum, i.e. 0..7.
  localparam int SUM_W = 3;

endpackage

// File: rtl/sum_accum_sat_add.sv
// Combinational saturating add of one 3-bit adder result into the running
// total. The add is done one bit wider than the total so the carry shows
// whether the result no longer fits; in that case the total pins at all-ones.
module sat_add
  import sum_accum_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [SUM_W-1:0] addend,
  output logic [ACC_W-1:0] sum_out,
  output logic             ovf_out
);

  logic [ACC_W:0] wide_sum;

  // Widened add, then clamp to the largest representable total on carry-out.
  always_comb begin
    wide_sum = {1'b0, acc_in} + {{(ACC_W + 1 - SUM_W){1'b0}}, addend};
    ovf_out  = wide_sum[ACC_W];
    sum_out  = wide_sum[ACC_W] ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
  end

endmodule

// File: rtl/sum_accum.sv
// Block accumulator: sums NUM_SAMPLES 3-bit adder results per block with
// valid/ready handshakes on both sides. A completed block is held until the
// consumer takes it; no input is accepted while a block is being held.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] NUM_CNT = CNT_W'(NUM_SAMPLES);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rdy_en_q, rdy_en_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_xfer;
  logic             out_xfer;

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_in  (acc_q),
    .addend  (in_sum),
    .sum_out (add_sum),
    .ovf_out (add_ovf)
  );

  // Handshake outputs come only from flops; rdy_en_q keeps in_ready low
  // during reset and releases it on the first edge after reset ends.
  always_comb begin
    in_ready  = rdy_en_q && (state_q != HOLD);
    out_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
    out_total = acc_q;
    out_ovf   = ovf_q;
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    cnt_inc   = cnt_q + CNT_W'(1);
  end

  // Next-state and datapath update; clear overrides every transfer.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rdy_en_d = 1'b1;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            acc_d   = {{(ACC_W - SUM_W){1'b0}}, in_sum};
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (NUM_CNT == CNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc_d = add_sum;
            ovf_d = ovf_q | add_ovf;
            cnt_d = cnt_inc;
            if (cnt_inc == NUM_CNT) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_xfer) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, discarded immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter NUM_SAMPLES, default 4: number of 3-bit adder results summed per output block; legal range 1..15.
REQ-002 Parameter ACC_W, default 8: accumulator and output width; legal range 4..16.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous abort; discards any partial block.
REQ-006 in_valid  input  1  in_sum carries a valid 3-bit adder result (carry-out plus 2-bit sum).
REQ-007 in_sum  input  3  unsigned adder result, range 0..7.
REQ-008 in_ready  output  1  block accepts in_sum this cycle.
REQ-009 out_valid  output  1  out_total and out_ovf hold a completed block.
REQ-010 out_total  output  ACC_W  accumulated block total.
REQ-011 out_ovf  output  1  the block total exceeded 2^ACC_W-1.
REQ-012 out_ready  input  1  consumer accepts the completed block.
REQ-013 busy  output  1  high in ACCUM or HOLD.

Function
REQ-014 Input transfer occurs on a rising edge where in_valid=1 and in_ready=1; output transfer occurs where out_valid=1 and out_ready=1.
REQ-015 FSM states: IDLE, ACCUM, HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD; out_valid=1 only in HOLD.
REQ-016 in_ready and out_valid are decoded from registered state only; no combinational path from any input to any output.
REQ-017 IDLE, on input transfer: acc <= zero-extended in_sum, cnt <= 1, ovf <= 0; next state HOLD if NUM_SAMPLES=1, otherwise ACCUM.
REQ-018 ACCUM, on input transfer: acc <= acc + in_sum, computed at ACC_W+1 bits; cnt <= cnt+1; next state HOLD when the new cnt equals NUM_SAMPLES.
REQ-019 ACCUM without a transfer holds acc, cnt and state; in_valid gaps of any length are legal.
REQ-020 Overflow: when the ACC_W+1-bit sum exceeds 2^ACC_W-1, acc saturates at 2^ACC_W-1 and ovf is set; ovf stays set until the next block starts.
REQ-021 Latency: out_valid asserts on the cycle after the clock edge carrying the NUM_SAMPLES-th input transfer.
REQ-022 HOLD: out_total=acc and out_ovf=ovf, stable while out_valid=1 and out_ready=0.
REQ-023 HOLD, on output transfer: next state IDLE; out_valid=0 the following cycle; earliest next input transfer is that following cycle.
REQ-024 in_valid during HOLD is ignored and no data is lost, because in_ready=0.
REQ-025 clear=1 overrides all other inputs: next state IDLE, acc=0, cnt=0, ovf=0; any coincident input or output transfer is void.
REQ-026 cnt width is 4 bits; cnt never exceeds NUM_SAMPLES.

Reset
REQ-027 While reset_n=0: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_total=0, out_ovf=0, busy=0, in_ready=0.
REQ-028 in_ready goes to 1 on the first rising edge after reset_n deasserts.
REQ-029 reset_n asserted mid-block or in HOLD discards all state immediately, without waiting for a clock edge.

Structure
REQ-030 Shared package sum_accum_pkg holds the state enum (IDLE, ACCUM, HOLD), the cnt width constant (4) and the in_sum width constant (3).
REQ-031 One sub-module, sat_add, holds the combinational ACC_W+1-bit add with saturation and overflow flag; the FSM and counter live in sum_accum.

Verification
REQ-032 Defaults; in_sum 7,7,7,7 on consecutive cycles; out_ready=1 -> out_valid one cycle after the 4th transfer, out_total=28, out_ovf=0, then back to IDLE.
REQ-033 Defaults; inputs 1,2,3,4 with 2-cycle in_valid gaps; out_ready=0 for 5 cycles -> out_total=10 held stable; in_ready=0 throughout HOLD; single output transfer when out_ready rises.
REQ-034 ACC_W=4; inputs 7,7,7,7 -> out_total=15, out_ovf=1; the next block of 1,1,1,1 -> out_total=4, out_ovf=0.
REQ-035 Defaults; inputs 5,5, then clear=1 in the same cycle as a third valid input -> IDLE, third input discarded; the next block 1,1,1,1 -> out_total=4.
REQ-036 reset_n pulsed low asynchronously, between clock edges, during HOLD -> out_valid=0 and out_total=0 immediately; the first post-reset block 2,2,2,2 -> out_total=8.
REQ-037 NUM_SAMPLES=1; in_valid held high with inputs 3,6 -> two blocks, out_total=3 then 6, each separated by one HOLD cycle with in_ready=0.
